mem_lsu: RTL

Memory-stage load/store unit of the in-order MIPS pipeline. Sits between the EX/MEM and MEM/CMT pipeline registers. Issues loads and stores to the data-side SRAM-like bus and aligns, sign- or zero-extends load data. Checks alignment and drives `stall_from_memory` into the pipeline control block while an access is outstanding.

---
 rtl/mem_lsu_if.sv | 40 ++++
 rtl/mem_lsu.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu_if.sv
// Data-side SRAM-like bus between the memory-stage LSU (master) and the data memory (slave).
// Requests use a two-phase addr_ok/data_ok handshake with one access outstanding.
interface mem_lsu_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [AW-1:0]     data_addr;
  logic [DW/8-1:0]   data_wstrb;
  logic [DW-1:0]     data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DW-1:0]     data_rdata;

  modport master (
    output data_req,
    output data_wr,
    output data_size,
    output data_addr,
    output data_wstrb,
    output data_wdata,
    input  data_addr_ok,
    input  data_data_ok,
    input  data_rdata
  );

  modport slave (
    input  data_req,
    input  data_wr,
    input  data_size,
    input  data_addr,
    input  data_wstrb,
    input  data_wdata,
    output data_addr_ok,
    output data_data_ok,
    output data_rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: issues one access at a time on the data bus, formats load
// data, checks alignment and stalls the pipeline while an access is outstanding.
module mem_lsu #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          in_valid,
  input  logic [3:0]    in_mem_op,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_wdata,
  input  logic [DW-1:0] in_alu_result,
  input  logic          flush,
  output logic          stall_from_memory,
  mem_lsu_if.master     bus,
  output logic          out_valid,
  output logic [DW-1:0] out_result,
  output logic [1:0]    out_exc,
  output logic [AW-1:0] out_badvaddr
);

  localparam logic [3:0] OpNone = 4'd0;
  localparam logic [3:0] OpLb   = 4'd1;
  localparam logic [3:0] OpLbu  = 4'd2;
  localparam logic [3:0] OpLh   = 4'd3;
  localparam logic [3:0] OpLhu  = 4'd4;
  localparam logic [3:0] OpLw   = 4'd5;
  localparam logic [3:0] OpSb   = 4'd6;
  localparam logic [3:0] OpSh   = 4'd7;
  localparam logic [3:0] OpSw   = 4'd8;

  localparam logic [1:0] ExcNone = 2'b00;
  localparam logic [1:0] ExcAdel = 2'b01;
  localparam logic [1:0] ExcAdes = 2'b10;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDrain} state_e;

  state_e        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          req;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op != OpNone) && (op <= OpSw);
  endfunction

  function automatic logic is_store_op(input logic [3:0] op);
    return (op == OpSb) || (op == OpSh) || (op == OpSw);
  endfunction

  // 0 byte, 1 half, 2 word
  function automatic logic [1:0] op_size(input logic [3:0] op);
    logic [1:0] size;
    case (op)
      OpLh, OpLhu, OpSh: size = 2'd1;
      OpLw, OpSw:        size = 2'd2;
      default:           size = 2'd0;
    endcase
    return size;
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lsb);
    logic [1:0] size;
    size = op_size(op);
    return ((size == 2'd1) && lsb[0]) || ((size == 2'd2) && (lsb != 2'b00));
  endfunction

  logic in_is_mem, in_is_store, in_misaligned;

  assign in_is_mem     = is_mem_op(in_mem_op);
  assign in_is_store   = is_store_op(in_mem_op);
  assign in_misaligned = is_misaligned(in_mem_op, in_addr[1:0]);

  // Store lane formatting from the latched access
  logic [DW/8-1:0] st_wstrb;
  logic [DW-1:0]   st_wdata;

  always_comb begin
    st_wstrb = '0;
    st_wdata = wdata_q;
    case (op_q)
      OpSb: begin
        st_wstrb = 4'b0001 << addr_q[1:0];
        st_wdata = {4{wdata_q[7:0]}};
      end
      OpSh: begin
        st_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata_q[15:0]}};
      end
      OpSw: st_wstrb = 4'b1111;
      default: ;
    endcase
  end

  // Load lane selection and extension
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [DW-1:0] ld_data;

  assign ld_byte = bus.data_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = bus.data_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = '0;
    case (op_q)
      OpLb:    ld_data = {{(DW-8){ld_byte[7]}}, ld_byte};
      OpLbu:   ld_data = {{(DW-8){1'b0}}, ld_byte};
      OpLh:    ld_data = {{(DW-16){ld_half[15]}}, ld_half};
      OpLhu:   ld_data = {{(DW-16){1'b0}}, ld_half};
      OpLw:    ld_data = bus.data_rdata;
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    state_d           = state_q;
    op_d              = op_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    req               = 1'b0;
    stall_from_memory = 1'b0;
    out_valid         = 1'b0;
    out_result        = '0;
    out_exc           = ExcNone;
    out_badvaddr      = '0;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (!in_is_mem) begin
            out_valid  = 1'b1;
            out_result = in_alu_result;
          end else if (in_misaligned) begin
            out_valid    = 1'b1;
            out_exc      = in_is_store ? ExcAdes : ExcAdel;
            out_badvaddr = in_addr;
          end else if (!flush) begin
            op_d              = in_mem_op;
            addr_d            = in_addr;
            wdata_d           = in_wdata;
            state_d           = StReq;
            stall_from_memory = 1'b1;
          end
        end
      end

      StReq: begin
        req               = 1'b1;
        stall_from_memory = 1'b1;
        // A flush before acceptance withdraws the request; after acceptance the data must drain
        if (flush) begin
          state_d = bus.data_addr_ok ? StDrain : StIdle;
        end else if (bus.data_addr_ok) begin
          state_d = StWait;
        end
      end

      StWait: begin
        stall_from_memory = !bus.data_data_ok;
        if (bus.data_data_ok) begin
          state_d = StIdle;
          if (!flush) begin
            out_valid  = 1'b1;
            out_result = ld_data;
          end
        end else if (flush) begin
          state_d = StDrain;
        end
      end

      StDrain: begin
        stall_from_memory = in_valid;
        if (bus.data_data_ok) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    if (!resetn) begin
      req               = 1'b0;
      stall_from_memory = 1'b0;
      out_valid         = 1'b0;
      out_exc           = ExcNone;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Bus fields come straight from the latched access, so they hold while a request waits
  assign bus.data_req   = req;
  assign bus.data_wr    = resetn && is_store_op(op_q);
  assign bus.data_size  = op_size(op_q);
  assign bus.data_addr  = addr_q;
  assign bus.data_wstrb = resetn ? st_wstrb : '0;
  assign bus.data_wdata = st_wdata;

  a_req_hold: assert property (@(posedge clk) disable iff (!resetn)
    (bus.data_req && !bus.data_addr_ok && !flush) |=>
      (bus.data_req && $stable(bus.data_addr) && $stable(bus.data_wstrb) &&
       $stable(bus.data_wdata) && $stable(bus.data_size)));

  a_no_result_while_req: assert property (@(posedge clk) disable iff (!resetn)
    !(bus.data_req && out_valid));

endmodule
